silife_frame_scheduler: RTL
===========================

Name: silife_frame_scheduler

Overview:
Sequences one frame of the SiLife system: a display refresh through the MAX7219 driver, then (optionally) one life-generation step.
- Arbitrates the single row-read port of the cell grid between the display driver (row_select) and the generation engine (row address).
- Paces frames with a programmable cycle prescaler.
- Sits between the top-level config registers, silife_max7219, and the grid/generation engine.

Parameters:
DIV_WIDTH, 24, width of frame prescaler and i_frame_div
ROW_BITS, 5, row address width (32 rows)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
i_enable  input  1  scheduler enable; 0 = stop issuing frames
i_run  input  1  1 = step one generation every frame
i_step  input  1  single-cycle pulse: request one generation at next frame (used when i_run=0)
i_frame_div  input  DIV_WIDTH  cycles per frame minus 1
o_disp_start  output  1  one-cycle pulse starting a display refresh (to driver i_enable/i_frame)
i_disp_busy  input  1  display driver busy
i_disp_row  input  ROW_BITS  display driver row_select
o_gen_start  output  1  one-cycle pulse starting one generation
i_gen_busy  input  1  generation engine busy
i_gen_row  input  ROW_BITS  engine row address
o_row_addr  output  ROW_BITS  muxed row address to grid read port
o_row_owner  output  1  0 = display owns port, 1 = engine owns port
o_busy  output  1  high in any state other than IDLE
o_tick  output  1  one-cycle pulse when prescaler wraps

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, prescaler 0, pending flags clear.
- Prescaler:
  - Counts 0..i_frame_div while i_enable=1 and wraps to 0.
  - o_tick pulses on the wrap cycle.
  - i_enable=0 holds the count at 0.
  - i_frame_div=0 gives a tick every cycle.
  - A change to i_frame_div takes effect at the next wrap; if the count already exceeds the new value, it wraps immediately.
- tick_pending: set by o_tick, cleared on entering DISP_START. A tick arriving while pending is already set is dropped (overrun).
- step_pending: set by an i_step pulse, cleared on entering GEN_START. Steps arriving while set are not queued.
- FSM:
  - IDLE: if tick_pending and i_enable -> DISP_START.
  - DISP_START: o_disp_start=1 for exactly 1 cycle -> DISP_WAIT; armed flag cleared.
  - DISP_WAIT: armed is set when i_disp_busy=1. When armed and i_disp_busy=0 -> GEN_CHECK.
  - GEN_CHECK (1 cycle): if i_run or step_pending -> GEN_START, else -> IDLE.
  - GEN_START: o_gen_start=1 for 1 cycle -> GEN_WAIT; armed cleared.
  - GEN_WAIT: arm on i_gen_busy=1. When armed and i_gen_busy=0 -> IDLE.
  - Frame latency: tick -> o_disp_start is 2 cycles from IDLE (tick registered into pending, then DISP_START).
- Arbitration:
  - o_row_owner=1 only in GEN_START/GEN_WAIT; otherwise 0.
  - o_row_addr = owner ? i_gen_row : i_disp_row (combinational mux on the registered owner).
  - Owner switches only at the state boundaries above, never mid-operation.
- i_enable deasserted mid-frame: the current display/generation runs to completion; no new frame starts afterwards. tick_pending is cleared while i_enable=0.
- Busy already high at start (driver still busy from an earlier frame): arms immediately. Completion still requires busy to fall.
- Asserting reset mid-operation returns everything to reset values asynchronously. Peripherals are reset by the same reset.

Optional Feature:
SILIFE_SCHED_OVERRUN_EN
- Defined: adds output o_overrun_count (8 bits). It increments, saturating at 255, each time a tick is dropped because tick_pending is already set. Cleared by reset only.
- Undefined: the port is absent; dropped ticks are silent.

Decomposition:
- Package silife_sched_pkg: FSM state enum (IDLE, DISP_START, DISP_WAIT, GEN_CHECK, GEN_START, GEN_WAIT), OWNER_DISP=0 / OWNER_GEN=1 constants, default ROW_BITS.
- One natural sub-module: silife_prescaler (counter + wrap tick with enable). Arbitration mux and FSM stay in the top.

Test Plan:
- i_frame_div=99, i_run=1, driver busy for 40 cycles, engine busy for 30 -> o_tick every 100 cycles. o_disp_start 2 cycles after each tick, o_gen_start 2 cycles after disp busy falls. o_busy high about 75 cycles per frame.
- i_run=0, no i_step -> o_disp_start every frame, o_gen_start never. One i_step pulse -> exactly one o_gen_start in the following frame.
- Ownership: drive i_disp_row=7, i_gen_row=19 -> o_row_addr=7 during DISP_WAIT and 19 during GEN_WAIT. Owner toggles only at GEN_START and on return to IDLE.
- Overrun: i_frame_div=9, display busy 50 cycles -> no back-to-back frames lost beyond one pending tick. With the macro defined, o_overrun_count increments per dropped tick and saturates at 255.
- Drop i_enable during DISP_WAIT -> the frame and its generation complete, then IDLE with no further o_disp_start. Re-enable -> next o_disp_start about i_frame_div+3 cycles later.
- Assert reset during GEN_WAIT -> all outputs 0 immediately. After release, the first o_disp_start follows the first tick.

Source files
------------

// File: rtl/silife_sched_pkg.sv
// Shared types and constants for the SiLife frame scheduler.
package silife_sched_pkg;

  localparam int unsigned ROW_BITS_DEF = 5;

  localparam logic OWNER_DISP = 1'b0;
  localparam logic OWNER_GEN  = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    DISP_START,
    DISP_WAIT,
    GEN_CHECK,
    GEN_START,
    GEN_WAIT
  } sched_state_t;

endpackage

// File: rtl/silife_prescaler.sv
// Frame prescaler: counts 0..i_div while enabled, ticks on the wrap cycle.
module silife_prescaler #(
  parameter int unsigned DIV_WIDTH = 24
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_enable,
  input  logic [DIV_WIDTH-1:0] i_div,
  output logic                 o_tick
);

  localparam logic [DIV_WIDTH-1:0] ONE = {{(DIV_WIDTH-1){1'b0}}, 1'b1};

  logic [DIV_WIDTH-1:0] count;

  // >= lets a shrunken divider wrap at once instead of running past it
  assign o_tick = i_enable && (count >= i_div);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (!i_enable || o_tick) begin
      count <= '0;
    end else begin
      count <= count + ONE;
    end
  end

endmodule

// File: rtl/silife_frame_scheduler.sv
// SiLife frame sequencer: display refresh, then an optional generation step, plus
// row-read port arbitration. Define SILIFE_SCHED_OVERRUN_EN to add o_overrun_count.
module silife_frame_scheduler
  import silife_sched_pkg::*;
#(
  parameter int unsigned DIV_WIDTH = 24,
  parameter int unsigned ROW_BITS  = ROW_BITS_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_enable,
  input  logic                 i_run,
  input  logic                 i_step,
  input  logic [DIV_WIDTH-1:0] i_frame_div,
  output logic                 o_disp_start,
  input  logic                 i_disp_busy,
  input  logic [ROW_BITS-1:0]  i_disp_row,
  output logic                 o_gen_start,
  input  logic                 i_gen_busy,
  input  logic [ROW_BITS-1:0]  i_gen_row,
  output logic [ROW_BITS-1:0]  o_row_addr,
  output logic                 o_row_owner,
  output logic                 o_busy,
`ifdef SILIFE_SCHED_OVERRUN_EN
  output logic                 o_tick,
  output logic [7:0]           o_overrun_count
`else
  output logic                 o_tick
`endif
);

  sched_state_t state, state_nxt;
  logic         armed, armed_nxt;
  logic         tick_pending, step_pending;
  logic         enter_disp, enter_gen;
  logic         row_owner;

  silife_prescaler #(
    .DIV_WIDTH(DIV_WIDTH)
  ) u_prescaler (
    .clk     (clk),
    .reset   (reset),
    .i_enable(i_enable),
    .i_div   (i_frame_div),
    .o_tick  (o_tick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      armed        <= 1'b0;
      tick_pending <= 1'b0;
      step_pending <= 1'b0;
    end else begin
      state        <= state_nxt;
      armed        <= armed_nxt;
      // A request arriving while its flag is already set is absorbed, not queued
      tick_pending <= i_enable && (tick_pending ? !enter_disp : o_tick);
      step_pending <= step_pending ? !enter_gen : i_step;
    end
  end

  always_comb begin
    state_nxt    = state;
    armed_nxt    = armed;
    o_disp_start = 1'b0;
    o_gen_start  = 1'b0;
    enter_disp   = 1'b0;
    enter_gen    = 1'b0;
    case (state)
      IDLE: begin
        if (tick_pending && i_enable) begin
          state_nxt  = DISP_START;
          enter_disp = 1'b1;
        end
      end
      DISP_START: begin
        o_disp_start = 1'b1;
        armed_nxt    = 1'b0;
        state_nxt    = DISP_WAIT;
      end
      DISP_WAIT: begin
        armed_nxt = armed | i_disp_busy;
        if (armed && !i_disp_busy) state_nxt = GEN_CHECK;
      end
      GEN_CHECK: begin
        if (i_run || step_pending) begin
          state_nxt = GEN_START;
          enter_gen = 1'b1;
        end else begin
          state_nxt = IDLE;
        end
      end
      GEN_START: begin
        o_gen_start = 1'b1;
        armed_nxt   = 1'b0;
        state_nxt   = GEN_WAIT;
      end
      GEN_WAIT: begin
        armed_nxt = armed | i_gen_busy;
        if (armed && !i_gen_busy) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign row_owner   = (state == GEN_START || state == GEN_WAIT) ? OWNER_GEN : OWNER_DISP;
  assign o_row_owner = row_owner;
  assign o_row_addr  = (row_owner == OWNER_GEN) ? i_gen_row : i_disp_row;
  assign o_busy      = (state != IDLE);

`ifdef SILIFE_SCHED_OVERRUN_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o_overrun_count <= '0;
    end else if (o_tick && tick_pending && (o_overrun_count != 8'hFF)) begin
      o_overrun_count <= o_overrun_count + 8'd1;
    end
  end
`endif

endmodule
